// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter indices, decoder FSM states, symbol encoding
// and the A-H pattern table (patterns right-aligned, first symbol most significant).
package morse_pkg;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_SPACE, ST_LONG} state_e;

  typedef enum logic {SYM_DOT = 1'b0, SYM_DASH = 1'b1} sym_e;

  localparam logic [2:0] NSYM_MAX = 3'd5;

  localparam logic [3:0] PAT_A = 4'b0001;  // .-
  localparam logic [3:0] PAT_B = 4'b1000;  // -...
  localparam logic [3:0] PAT_C = 4'b1010;  // -.-.
  localparam logic [3:0] PAT_D = 4'b0100;  // -..
  localparam logic [3:0] PAT_E = 4'b0000;  // .
  localparam logic [3:0] PAT_F = 4'b0010;  // ..-.
  localparam logic [3:0] PAT_G = 4'b0110;  // --.
  localparam logic [3:0] PAT_H = 4'b0000;  // ....

  localparam logic [2:0] LEN_A = 3'd2;
  localparam logic [2:0] LEN_B = 3'd4;
  localparam logic [2:0] LEN_C = 3'd4;
  localparam logic [2:0] LEN_D = 3'd3;
  localparam logic [2:0] LEN_E = 3'd1;
  localparam logic [2:0] LEN_F = 3'd4;
  localparam logic [2:0] LEN_G = 3'd3;
  localparam logic [2:0] LEN_H = 3'd4;

  function automatic logic [3:0] letter_pat(input logic [2:0] l);
    case (l)
      LTR_A:   return PAT_A;
      LTR_B:   return PAT_B;
      LTR_C:   return PAT_C;
      LTR_D:   return PAT_D;
      LTR_E:   return PAT_E;
      LTR_F:   return PAT_F;
      LTR_G:   return PAT_G;
      default: return PAT_H;
    endcase
  endfunction

  function automatic logic [2:0] letter_len(input logic [2:0] l);
    case (l)
      LTR_A:   return LEN_A;
      LTR_B:   return LEN_B;
      LTR_C:   return LEN_C;
      LTR_D:   return LEN_D;
      LTR_E:   return LEN_E;
      LTR_F:   return LEN_F;
      LTR_G:   return LEN_G;
      default: return LEN_H;
    endcase
  endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Decoder-side signal bundle: Morse stream in, decoded letter and status out.
interface morse_decoder_if;
  logic       b_in;
  logic [2:0] letter_out;
  logic       valid;
  logic       error;
  logic       busy;

  modport master (output b_in, input letter_out, input valid, input error, input busy);
  modport slave  (input b_in, output letter_out, output valid, output error, output busy);
endinterface

// File: rtl/morse_pattern_lut.sv
// Combinational pattern lookup: symbol store plus symbol count to letter index and match flag.
module morse_pattern_lut
  import morse_pkg::*;
(
  input  logic [3:0] store_i,
  input  logic [2:0] nsym_i,
  output logic [2:0] letter_o,
  output logic       match_o
);

  // Store bits above nsym are zero (cleared at letter start), so a full 4-bit compare suffices.
  always_comb begin
    letter_o = '0;
    match_o  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (nsym_i == letter_len(3'(i)) && store_i == letter_pat(3'(i))) begin
        letter_o = 3'(i);
        match_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receive decoder: classifies marks by width and decodes 1-4 symbol letters A-H.
// Define MORSE_DEC_SYNC_EN to pass b_in through a 2-flop synchronizer.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input logic            clk,
  input logic            reset,
  morse_decoder_if.slave mdec
);

  localparam int unsigned CW = $clog2(6 * UNIT_CYCLES + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX  = cnt_t'(6 * UNIT_CYCLES);
  localparam cnt_t DASH_MIN = cnt_t'(2 * UNIT_CYCLES);
  localparam cnt_t LONG_LIM = cnt_t'(4 * UNIT_CYCLES + 1);
  localparam cnt_t GAP_LIM  = cnt_t'(2 * UNIT_CYCLES);

  logic b_s;

`ifdef MORSE_DEC_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], mdec.b_in};
  end
  assign b_s = sync_q[1];
`else
  assign b_s = mdec.b_in;
`endif

  state_e     state_q, state_d;
  logic       prev_q;
  cnt_t       cnt_q, run;
  logic [3:0] store_q, store_d;
  logic [2:0] nsym_q, nsym_d;
  logic [2:0] letter_q, letter_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic [2:0] lut_letter;
  logic       lut_match;
  sym_e       sym;

  // run is the width of the current level including the sample being registered
  always_comb begin
    if (b_s != prev_q)      run = cnt_t'(1);
    else if (cnt_q == CNT_MAX) run = CNT_MAX;
    else                    run = cnt_q + cnt_t'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      store_q  <= '0;
      nsym_q   <= '0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= b_s;
      cnt_q    <= run;
      store_q  <= store_d;
      nsym_q   <= nsym_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (b_s) state_d = ST_MARK;
      ST_MARK: begin
        if (!b_s)                 state_d = ST_SPACE;
        else if (run == LONG_LIM) state_d = ST_LONG;
      end
      ST_SPACE: begin
        if (b_s)                 state_d = ST_MARK;
        else if (run == GAP_LIM) state_d = ST_IDLE;
      end
      ST_LONG:  if (!b_s && run == GAP_LIM) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  morse_pattern_lut u_lut (
    .store_i  (store_q),
    .nsym_i   (nsym_q),
    .letter_o (lut_letter),
    .match_o  (lut_match)
  );

  always_comb begin
    store_d  = store_q;
    nsym_d   = nsym_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    sym      = (cnt_q < DASH_MIN) ? SYM_DOT : SYM_DASH;
    case (state_q)
      ST_IDLE: begin
        if (b_s) begin
          store_d = '0;
          nsym_d  = '0;
        end
      end
      ST_MARK: begin
        // On the falling sample cnt_q still holds the full mark width.
        if (!b_s) begin
          store_d = {store_q[2:0], sym};
          nsym_d  = (nsym_q == NSYM_MAX) ? nsym_q : nsym_q + 3'd1;
        end
      end
      ST_SPACE: begin
        if (!b_s && run == GAP_LIM) begin
          if (lut_match) begin
            valid_d  = 1'b1;
            letter_d = lut_letter;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_LONG:  if (!b_s && run == GAP_LIM) error_d = 1'b1;
      default: ;
    endcase
  end

  assign mdec.letter_out = letter_q;
  assign mdec.valid      = valid_q;
  assign mdec.error      = error_q;
  assign mdec.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder (U=4) against a string-based Morse reference model.
module tb_morse_decoder;

  localparam int U = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  morse_decoder_if mif ();

  morse_decoder #(.UNIT_CYCLES(U)) dut (
    .clk   (clk),
    .reset (reset),
    .mdec  (mif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pk[$];
  int pl[$];
  int pc[$];
  int both_cnt  = 0;
  int busy_gaps = 0;
  bit in_letter = 1'b0;
  int letter_start = 0;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_letter = 0;

  always @(negedge clk) begin
    if (mif.valid && mif.error) both_cnt++;
    if (mif.valid || mif.error) begin
      pk.push_back(mif.valid ? 1 : 2);
      pl.push_back(int'(mif.letter_out));
      pc.push_back(cyc);
    end
    if (in_letter && cyc > letter_start && pc.size() == 0 && !mif.busy) busy_gaps++;
  end

  function automatic string pat_str(input int k);
    case (k)
      0: return ".-";
      1: return "-...";
      2: return "-.-.";
      3: return "-..";
      4: return ".";
      5: return "..-.";
      6: return "--.";
      default: return "....";
    endcase
  endfunction

  // kind 1 = valid with letter, kind 2 = error
  function automatic void model(input int w[$], output int kind, output int letter);
    string s = "";
    bit lng = 1'b0;
    for (int i = 0; i < w.size(); i += 2) begin
      if (w[i] > 4 * U) lng = 1'b1;
      s = {s, (w[i] < 2 * U) ? "." : "-"};
    end
    kind = 2;
    letter = -1;
    if (!lng)
      for (int k = 0; k < 8; k++)
        if (s == pat_str(k)) begin
          kind = 1;
          letter = k;
        end
  endfunction

  function automatic void encode(input string s, output int w[$]);
    w = {};
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) w.push_back(U);
      w.push_back(s[i] == "." ? U : 3 * U);
    end
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 mif.b_in = v;
    end
  endtask

  task automatic run_letter(input int w[$], output int stamp, output int base);
    base = pk.size();
    letter_start = cyc + 1;
    in_letter = 1'b1;
    foreach (w[i]) drive((i % 2) == 0, w[i]);
    stamp = cyc + 1 + 2 * U;
    drive(1'b0, 2 * U + 4);
    in_letter = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mif.b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mif.letter_out !== 3'd0) $display("FAIL reset_letter: got %0d want 0", mif.letter_out);
    else n_pass++;
    n_checks++;
    if (mif.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", mif.valid);
    else n_pass++;
    n_checks++;
    if (mif.error !== 1'b0) $display("FAIL reset_error: got %b want 0", mif.error);
    else n_pass++;
    n_checks++;
    if (mif.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", mif.busy);
    else n_pass++;
    exp_letter = 0;
    drive(1'b0, 2);
  endtask

  task automatic test_letter_a();
    int w[$];
    int k, l, st, b;
    w = '{4, 4, 12};
    model(w, k, l);
    run_letter(w, st, b);
    if (k == 1) exp_letter = l;
    n_checks++;
    if (pk.size() != b + 1 || pk[b] != k || pc[b] != st || (k == 1 && pl[b] != l) ||
        int'(mif.letter_out) != exp_letter)
      $display("FAIL letter_a: pulses=%0d kind=%0d letter=%0d cycle=%0d out=%0d, want 1 pulse kind=%0d letter=%0d cycle=%0d out=%0d",
               pk.size() - b, qat(pk, b), qat(pl, b), qat(pc, b), mif.letter_out, k, l, st, exp_letter);
    else n_pass++;
  endtask

  task automatic test_letter_h();
    int w[$];
    int k, l, st, b, g0;
    w = '{4, 4, 4, 4, 4, 4, 4};
    g0 = busy_gaps;
    model(w, k, l);
    run_letter(w, st, b);
    if (k == 1) exp_letter = l;
    n_checks++;
    if (pk.size() != b + 1 || pk[b] != k || pc[b] != st || (k == 1 && pl[b] != l) ||
        int'(mif.letter_out) != exp_letter)
      $display("FAIL letter_h: pulses=%0d kind=%0d letter=%0d cycle=%0d out=%0d, want 1 pulse kind=%0d letter=%0d cycle=%0d out=%0d",
               pk.size() - b, qat(pk, b), qat(pl, b), qat(pc, b), mif.letter_out, k, l, st, exp_letter);
    else n_pass++;
    n_checks++;
    if (busy_gaps != g0) $display("FAIL busy_h: busy low for %0d cycles, want 0", busy_gaps - g0);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    int w[$];
    int k, l, st, b;
    for (int t = 0; t < 5; t++) begin
      case (t)
        0: w = '{2 * U - 1};
        1: w = '{2 * U};
        2: w = '{2 * U - 1, 2 * U - 1, 4 * U};
        3: w = '{4 * U, U, U, U, U};
        default: w = '{4 * U + 1, U, U, U, U};
      endcase
      model(w, k, l);
      run_letter(w, st, b);
      if (k == 1) exp_letter = l;
      n_checks++;
      if (pk.size() != b + 1 || pk[b] != k || pc[b] != st || (k == 1 && pl[b] != l) ||
          int'(mif.letter_out) != exp_letter)
        $display("FAIL boundary_%0d: pulses=%0d kind=%0d letter=%0d cycle=%0d out=%0d, want 1 pulse kind=%0d letter=%0d cycle=%0d out=%0d",
                 t, pk.size() - b, qat(pk, b), qat(pl, b), qat(pc, b), mif.letter_out, k, l, st, exp_letter);
      else n_pass++;
    end
  endtask

  task automatic test_timing_faults();
    int w[$];
    int k, l, st, b;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: w = '{20};
        1: w = '{U, U, 3 * U};
        default: w = '{U, U, U, U, U, U, U, U, U};
      endcase
      model(w, k, l);
      run_letter(w, st, b);
      if (k == 1) exp_letter = l;
      n_checks++;
      if (pk.size() != b + 1 || pk[b] != k || pc[b] != st || (k == 1 && pl[b] != l) ||
          int'(mif.letter_out) != exp_letter)
        $display("FAIL fault_%0d: pulses=%0d kind=%0d letter=%0d cycle=%0d out=%0d, want 1 pulse kind=%0d letter=%0d cycle=%0d out=%0d",
                 t, pk.size() - b, qat(pk, b), qat(pl, b), qat(pc, b), mif.letter_out, k, l, st, exp_letter);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int w[$];
    int k, l, st, b;
    b = pk.size();
    drive(1'b1, U);
    drive(1'b0, U);
    drive(1'b1, U);
    drive(1'b0, 2);
    reset = 1'b1;
    drive(1'b0, 2);
    reset = 1'b0;
    exp_letter = 0;
    drive(1'b0, 2 * U + 4);
    n_checks++;
    if (pk.size() != b || mif.busy !== 1'b0 || int'(mif.letter_out) != 0)
      $display("FAIL reset_mid: pulses=%0d busy=%b out=%0d, want 0 pulses busy=0 out=0",
               pk.size() - b, mif.busy, mif.letter_out);
    else n_pass++;
    encode("-..", w);
    model(w, k, l);
    run_letter(w, st, b);
    if (k == 1) exp_letter = l;
    n_checks++;
    if (pk.size() != b + 1 || pk[b] != k || pc[b] != st || (k == 1 && pl[b] != l) ||
        int'(mif.letter_out) != exp_letter)
      $display("FAIL after_reset_d: pulses=%0d kind=%0d letter=%0d cycle=%0d out=%0d, want 1 pulse kind=%0d letter=%0d cycle=%0d out=%0d",
               pk.size() - b, qat(pk, b), qat(pl, b), qat(pc, b), mif.letter_out, k, l, st, exp_letter);
    else n_pass++;
  endtask

  task automatic test_loopback();
    int w[$];
    int st, b;
    for (int L = 0; L < 8; L++) begin
      encode(pat_str(L), w);
      run_letter(w, st, b);
      exp_letter = L;
      n_checks++;
      if (pk.size() != b + 1 || pk[b] != 1 || pc[b] != st || pl[b] != L || int'(mif.letter_out) != L)
        $display("FAIL loopback_%0d: pulses=%0d kind=%0d letter=%0d cycle=%0d, want 1 pulse kind=1 letter=%0d cycle=%0d",
                 L, pk.size() - b, qat(pk, b), qat(pl, b), qat(pc, b), L, st);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int w[$];
    int k, l, st, b, n, c;
    for (int t = 0; t < 40; t++) begin
      w = {};
      n = int'($urandom_range(1, 5));
      for (int s = 0; s < n; s++) begin
        if (s > 0) w.push_back(int'($urandom_range(1, 2 * U - 1)));
        c = int'($urandom_range(0, 9));
        if (c < 5)      w.push_back(int'($urandom_range(1, 2 * U - 1)));
        else if (c < 9) w.push_back(int'($urandom_range(2 * U, 4 * U)));
        else            w.push_back(int'($urandom_range(4 * U + 1, 6 * U + 4)));
      end
      model(w, k, l);
      run_letter(w, st, b);
      if (k == 1) exp_letter = l;
      n_checks++;
      if (pk.size() != b + 1 || pk[b] != k || pc[b] != st || (k == 1 && pl[b] != l) ||
          int'(mif.letter_out) != exp_letter)
        $display("FAIL random_%0d: pulses=%0d kind=%0d letter=%0d cycle=%0d out=%0d, want 1 pulse kind=%0d letter=%0d cycle=%0d out=%0d",
                 t, pk.size() - b, qat(pk, b), qat(pl, b), qat(pc, b), mif.letter_out, k, l, st, exp_letter);
      else n_pass++;
    end
  endtask

  initial begin
    mif.b_in = 1'b0;
    test_reset();
    test_letter_a();
    test_letter_h();
    test_boundaries();
    test_timing_faults();
    test_reset_mid();
    test_loopback();
    test_random();
    n_checks++;
    if (both_cnt != 0) $display("FAIL valid_error_overlap: %0d cycles, want 0", both_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
